// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
//   Feeds operand pairs to a repeated-addition multiplier one at a time.
//   A small FIFO buffers the pairs. The FSM (IDLE/ISSUE/WAIT/HOLD) pulses
//   mul_start and keeps mul_a/mul_b steady until the op completes. It then
//   captures the product, or a timeout marker when mul_done never arrives,
//   and offers it on a valid/ready result port together with an 8-bit
//   issue tag.
//
//   Optional feature: define MULT_SEQ_CHECK_EN to recompute a*b when the
//   product is captured. res_err is set on a mismatch. Without the macro,
//   res_err is tied to 0 and no multiplier is built.
//
// Ports
//   clock, reset            clock; synchronous active-low reset
//   in_valid/in_ready       operand push handshake (in_ready = !full)
//   in_a, in_b              operand pair
//   fifo_count              entries currently buffered
//   mul_start               one-cycle start pulse to the multiplier
//   mul_a, mul_b            operands held from ISSUE to the end of WAIT
//   mul_done, mul_product   completion strobe and result from the multiplier
//   res_valid/res_ready     result handshake
//   res_product, res_tag    captured product and its issue sequence number
//   res_timeout, res_err    timeout flag and checker mismatch flag
module mult_operand_sequencer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_product,
    output logic [7:0]               res_tag,
    output logic                     res_timeout,
    output logic                     res_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    state_t            state_q, state_d;
    pair_t             mem_q [DEPTH];
    pair_t             mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        tag_q, tag_d, op_tag_q, op_tag_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [WIDTH-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic              res_valid_q, res_valid_d;
    logic [PW-1:0]     res_product_q, res_product_d;
    logic [7:0]        res_tag_q, res_tag_d;
    logic              res_timeout_q, res_timeout_d;
    logic              push, issue;
`ifdef MULT_SEQ_CHECK_EN
    logic              res_err_q, res_err_d;
    logic [PW-1:0]     expect_prod;
`endif

    // Ready is held low while reset is asserted, not only once the FIFO is full.
    assign in_ready    = reset && (count_q != FULL_CNT);
    assign fifo_count  = count_q;
    assign mul_start   = (state_q == S_ISSUE);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;
    assign res_tag     = res_tag_q;
    assign res_timeout = res_timeout_q;
`ifdef MULT_SEQ_CHECK_EN
    assign res_err     = res_err_q;
`else
    assign res_err     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_d         = tag_q;
        op_tag_d      = op_tag_q;
        tmo_d         = tmo_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        res_tag_d     = res_tag_q;
        res_timeout_d = res_timeout_q;
        push          = in_valid && in_ready;
        issue         = 1'b0;
`ifdef MULT_SEQ_CHECK_EN
        res_err_d     = res_err_q;
        expect_prod   = {{WIDTH{1'b0}}, mul_a_q} * {{WIDTH{1'b0}}, mul_b_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) issue = 1'b1;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done that arrives on the timeout cycle still produces a normal result.
                if (mul_done) begin
                    state_d       = S_HOLD;
                    res_valid_d   = 1'b1;
                    res_product_d = mul_product;
                    res_tag_d     = op_tag_q;
                    res_timeout_d = 1'b0;
`ifdef MULT_SEQ_CHECK_EN
                    res_err_d     = (mul_product != expect_prod);
`endif
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = S_HOLD;
                    res_valid_d   = 1'b1;
                    res_product_d = '0;
                    res_tag_d     = op_tag_q;
                    res_timeout_d = 1'b1;
`ifdef MULT_SEQ_CHECK_EN
                    res_err_d     = 1'b0;
`endif
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != '0) issue = 1'b1;
                    else               state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // All ISSUE-entry work happens on the transition edge, so the operands
        // are already valid during the cycle in which mul_start is high.
        if (issue) begin
            state_d  = S_ISSUE;
            mul_a_d  = mem_q[rd_ptr_q].a;
            mul_b_d  = mem_q[rd_ptr_q].b;
            rd_ptr_d = rd_ptr_q + AW'(1);
            op_tag_d = tag_q;
            tag_d    = tag_q + 8'd1;
            tmo_d    = '0;
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{a: in_a, b: in_b};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, issue};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tag_q         <= '0;
            op_tag_q      <= '0;
            tmo_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            res_tag_q     <= '0;
            res_timeout_q <= 1'b0;
`ifdef MULT_SEQ_CHECK_EN
            res_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tag_q         <= tag_d;
            op_tag_q      <= op_tag_d;
            tmo_q         <= tmo_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            res_tag_q     <= res_tag_d;
            res_timeout_q <= res_timeout_d;
`ifdef MULT_SEQ_CHECK_EN
            res_err_q     <= res_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer
//   Directed bench for mult_operand_sequencer (WIDTH=4, DEPTH=4, TIMEOUT=20).
//   The bench plays the multiplier role by driving mul_done/mul_product by hand.
module tb_mult_operand_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic [2:0] fifo_count;
    logic       mul_start;
    logic [3:0] mul_a, mul_b;
    logic       mul_done;
    logic [7:0] mul_product;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_product;
    logic [7:0] res_tag;
    logic       res_timeout;
    logic       res_err;

    int total = 0;
    int bad   = 0;

    mult_operand_sequencer #(.WIDTH(4), .DEPTH(4), .TIMEOUT(20)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .fifo_count(fifo_count),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product), .res_tag(res_tag),
        .res_timeout(res_timeout), .res_err(res_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        mul_done = 1'b0; mul_product = '0; res_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_product", res_product, 0);
        chk("rst_tag", res_tag, 0);
        chk("rst_timeout", res_timeout, 0);
        chk("rst_err", res_err, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Single op: (3,5), done after 4 cycles with 15
        push_pair(4'd3, 4'd5);
        chk("single_count1", fifo_count, 1);
        chk("single_no_start_yet", mul_start, 0);
        tick();
        chk("single_start", mul_start, 1);
        chk("single_mul_a", mul_a, 3);
        chk("single_mul_b", mul_b, 5);
        chk("single_count0", fifo_count, 0);
        tick();
        chk("single_start_once", mul_start, 0);
        tick(); tick(); tick();
        chk("single_wait_valid", res_valid, 0);
        mul_done = 1'b1; mul_product = 8'd15;
        tick();
        mul_done = 1'b0; mul_product = 8'd0;
        chk("single_valid", res_valid, 1);
        chk("single_product", res_product, 15);
        chk("single_tag", res_tag, 0);
        chk("single_timeout", res_timeout, 0);
        chk("single_err", res_err, 0);
        tick();
        chk("single_hold_valid", res_valid, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_accept_valid", res_valid, 0);
        chk("single_mul_a_hold", mul_a, 3);
        chk("single_idle_start", mul_start, 0);

        // Fill: 5 pushes, first issued, 4 buffered
        push_pair(4'd1, 4'd2);
        push_pair(4'd2, 4'd3);
        chk("fill_start_p0", mul_start, 1);
        push_pair(4'd3, 4'd4);
        push_pair(4'd4, 4'd5);
        push_pair(4'd5, 4'd6);
        chk("fill_count4", fifo_count, 4);
        chk("fill_in_ready0", in_ready, 0);
        push_pair(4'd9, 4'd9);
        chk("fill_push_ignored", fifo_count, 4);
        chk("fill_mul_a", mul_a, 1);
        chk("fill_mul_b", mul_b, 2);
        mul_done = 1'b1; mul_product = 8'd2;
        tick();
        mul_done = 1'b0; mul_product = 8'd0;
        chk("fill_valid", res_valid, 1);
        chk("fill_product", res_product, 2);
        chk("fill_tag", res_tag, 1);

        // Backpressure for 10 cycles, with a stray done mid-way
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin mul_done = 1'b1; mul_product = 8'd99; end
            tick();
            mul_done = 1'b0; mul_product = 8'd0;
            chk("bp_no_start", mul_start, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_product", res_product, 2);
            chk("bp_tag", res_tag, 1);
        end
        chk("bp_count", fifo_count, 4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("b2b_valid0", res_valid, 0);
        chk("b2b_start", mul_start, 1);
        chk("b2b_mul_a", mul_a, 2);
        chk("b2b_mul_b", mul_b, 3);
        chk("b2b_count", fifo_count, 3);
        chk("b2b_in_ready", in_ready, 1);

        // Timeout: no done; result exactly 20 cycles after WAIT entry
        tick();
        chk("tmo_in_wait", mul_start, 0);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("tmo_not_yet", res_valid, 0);
        end
        tick();
        chk("tmo_valid", res_valid, 1);
        chk("tmo_flag", res_timeout, 1);
        chk("tmo_product", res_product, 0);
        chk("tmo_tag", res_tag, 2);
        chk("tmo_err", res_err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("after_tmo_start", mul_start, 1);
        chk("after_tmo_mul_a", mul_a, 3);
        tick();
        mul_done = 1'b1; mul_product = 8'd12;
        tick();
        mul_done = 1'b0; mul_product = 8'd0;
        chk("after_tmo_product", res_product, 12);
        chk("after_tmo_tag", res_tag, 3);
        chk("after_tmo_flag", res_timeout, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Done on the timeout cycle wins
        tick();
        for (int i = 1; i < 20; i++) tick();
        chk("race_not_yet", res_valid, 0);
        mul_done = 1'b1; mul_product = 8'd20;
        tick();
        mul_done = 1'b0; mul_product = 8'd0;
        chk("race_valid", res_valid, 1);
        chk("race_flag", res_timeout, 0);
        chk("race_product", res_product, 20);
        chk("race_tag", res_tag, 4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("race_next_start", mul_start, 1);
        chk("race_next_count", fifo_count, 0);

        // Reset during WAIT with 2 queued
        push_pair(4'd7, 4'd1);
        push_pair(4'd7, 4'd2);
        chk("mid_count2", fifo_count, 2);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_count0", fifo_count, 0);
        chk("mid_valid0", res_valid, 0);
        chk("mid_start0", mul_start, 0);
        chk("mid_mul_a0", mul_a, 0);
        push_pair(4'd6, 4'd7);
        tick();
        chk("mid_start", mul_start, 1);
        tick();
        mul_done = 1'b1; mul_product = 8'd42;
        tick();
        mul_done = 1'b0; mul_product = 8'd0;
        chk("mid_product", res_product, 42);
        chk("mid_tag0", res_tag, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

`ifdef MULT_SEQ_CHECK_EN
        push_pair(4'd15, 4'd15);
        tick(); tick();
        mul_done = 1'b1; mul_product = 8'd224;
        tick();
        mul_done = 1'b0;
        chk("chk_err1", res_err, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        push_pair(4'd15, 4'd15);
        tick(); tick();
        mul_done = 1'b1; mul_product = 8'd225;
        tick();
        mul_done = 1'b0;
        chk("chk_err0", res_err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
